// File: rtl/cl_net_pkg.sv
// rtl/cl_net_pkg.sv - shared CRC-32 constants, FCS checker state type and byte-wise CRC update
package cl_net_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam int          FCS_BYTES       = 4;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PASS = 2'd1,
        STAT = 2'd2
    } fcs_chk_state_e;

    // Reflected CRC-32, data enters LSB first; no final inversion applied here.
    function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cl_byte_delay_line.sv
// rtl/cl_byte_delay_line.sv - 4-deep byte shift FIFO with fill count that holds back the trailing FCS
module cl_byte_delay_line
    import cl_net_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] head_data,
    output logic [2:0] fill_count
);

    logic [7:0] mem [FCS_BYTES];
    logic [2:0] count;

    assign head_data  = mem[0];
    assign fill_count = count;

    // Oldest byte always sits in mem[0]; a pop shifts everything one slot toward the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < FCS_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    mem[count[1:0]] <= push_data;
                    count           <= count + 3'd1;
                end
                2'b01: begin
                    for (int i = 0; i < FCS_BYTES - 1; i++) begin
                        mem[i] <= mem[i+1];
                    end
                    count <= count - 3'd1;
                end
                2'b11: begin
                    for (int i = 0; i < FCS_BYTES - 1; i++) begin
                        mem[i] <= mem[i+1];
                    end
                    mem[2'(count - 3'd1)] <= push_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cl_fcs_checker.sv
// rtl/cl_fcs_checker.sv - receive-side FCS checker: strips trailing CRC-32, forwards payload, reports frame status
module cl_fcs_checker
    import cl_net_pkg::*;
#(
    parameter int          MAX_LEN     = 1518,
    parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        stat_valid,
    input  logic        stat_ready,
    output logic        stat_crc_ok,
    output logic        stat_runt,
    output logic        stat_too_long,
    output logic [15:0] stat_len
);

    fcs_chk_state_e state, state_next;
    logic [31:0]    crc, crc_next;
    logic [15:0]    len, len_next;
    logic           accept, push, pop, clear;
    logic [7:0]     head_data;
    logic [2:0]     fill_count;

    assign in_ready = rst_n && (state != STAT) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    cl_byte_delay_line u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .push_data  (in_data),
        .head_data  (head_data),
        .fill_count (fill_count)
    );

    always_comb begin
        state_next = state;
        crc_next   = crc;
        len_next   = len;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        case (state)
            FILL, PASS: begin
                if (accept) begin
                    push     = 1'b1;
                    crc_next = crc32_byte_update(crc, in_data);
                    if (state == PASS) begin
                        pop      = 1'b1;
                        len_next = (len == 16'hFFFF) ? len : len + 16'd1;
                    end
                    if (in_last) begin
                        state_next = STAT;
                    end else if (state == FILL && fill_count == 3'(FCS_BYTES - 1)) begin
                        state_next = PASS;
                    end
                end
            end
            STAT: begin
                if (stat_valid && stat_ready) begin
                    clear      = 1'b1;
                    crc_next   = CRC32_INIT;
                    len_next   = '0;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            crc           <= CRC32_INIT;
            len           <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            stat_valid    <= 1'b0;
            stat_crc_ok   <= 1'b0;
            stat_runt     <= 1'b0;
            stat_too_long <= 1'b0;
            stat_len      <= '0;
        end else begin
            state <= state_next;
            crc   <= crc_next;
            len   <= len_next;

            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= head_data;
                out_last  <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A frame ending while still filling never produced payload: it is a runt.
            if (accept && in_last) begin
                stat_valid    <= 1'b1;
                stat_runt     <= (state == FILL);
                stat_crc_ok   <= (state == PASS) && (crc_next == CRC_RESIDUE);
                stat_too_long <= ({16'd0, len_next} > 32'(MAX_LEN));
                stat_len      <= (state == FILL) ? 16'd0 : len_next;
            end else if (stat_valid && stat_ready) begin
                stat_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cl_fcs_checker.sv
// tb/tb_cl_fcs_checker.sv - randomized self-checking bench for cl_fcs_checker against a frame-level model
`timescale 1ns/1ps
module tb_cl_fcs_checker;

    localparam int TB_MAX = 20;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic        ok;
        logic        runt;
        logic        tl;
        logic [15:0] len;
    } stat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  out_data;
    logic        stat_valid, stat_ready, stat_crc_ok, stat_runt, stat_too_long;
    logic [15:0] stat_len;

    always #5 clk = ~clk;

    cl_fcs_checker #(.MAX_LEN(TB_MAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .stat_valid    (stat_valid),
        .stat_ready    (stat_ready),
        .stat_crc_ok   (stat_crc_ok),
        .stat_runt     (stat_runt),
        .stat_too_long (stat_too_long),
        .stat_len      (stat_len)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_mode = 0;
    int stat_wait = 0;
    bit gaps = 1'b0;
    int out_hs = 0;
    int stat_hs = 0;
    int stat_hs_cyc = 0;
    int start_cyc = 0;
    stat_t last_stat;
    logic [8:0] exp_out [$];
    stat_t exp_stat [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Standard CRC-32 of the first n bytes, bit-serial, final inversion applied.
    function automatic logic [31:0] ref_crc(input byte_q_t d, input int n);
        logic [31:0] r;
        logic fb;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ d[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return ~r;
    endfunction

    function automatic byte_q_t with_fcs(input byte_q_t p);
        byte_q_t r;
        logic [31:0] c;
        r = p;
        c = ref_crc(p, p.size());
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
        r.push_back(c[23:16]);
        r.push_back(c[31:24]);
        return r;
    endfunction

    task automatic expect_frame(input byte_q_t f);
        int n;
        int plen;
        stat_t s;
        logic [31:0] fcs;
        n      = f.size();
        s.runt = (n < 5);
        plen   = s.runt ? 0 : n - 4;
        for (int i = 0; i < plen; i++) exp_out.push_back({logic'(i == plen - 1), f[i]});
        if (s.runt) begin
            s.ok = 1'b0;
        end else begin
            fcs  = {f[n-1], f[n-2], f[n-3], f[n-4]};
            s.ok = (ref_crc(f, plen) == fcs);
        end
        s.len = 16'(plen);
        s.tl  = (plen > TB_MAX);
        exp_stat.push_back(s);
    endtask

    task automatic send_bytes(input byte_q_t f, input int n, input bit hold);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = f[i];
            in_last  = (i == f.size() - 1);
            w = 0;
            forever begin
                @(negedge clk);
                if (in_ready) begin
                    if (i == 0) start_cyc = cyc;
                    @(posedge clk);
                    #1;
                    break;
                end
                w++;
                if (w > 2000) begin
                    chk("accept_timeout", 32'(w), 32'd0);
                    break;
                end
            end
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_out.size() != 0 || exp_stat.size() != 0) && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 1000) chk("drain_timeout", 32'(w), 32'd0);
    endtask

    task automatic run_frame(input byte_q_t f);
        expect_frame(f);
        send_bytes(f, f.size(), 1'b0);
        drain();
    endtask

    // Sink-side ready generation: out_ready per mode, stat_ready after stat_wait cycles of stat_valid.
    initial begin
        int phase;
        int scnt;
        logic [3:0] pat;
        phase = 0;
        scnt = 0;
        pat = 4'b1001;
        out_ready = 1'b0;
        stat_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[phase];
                    phase = (phase + 1) % 4;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stat_valid) scnt++;
            else scnt = 0;
            stat_ready = (scnt > stat_wait);
        end
    end

    // Monitor: scoreboards outputs and checks hold/ready rules, sampled mid-cycle.
    logic       p_ostall = 1'b0, p_sstall = 1'b0;
    logic [8:0] p_out;
    logic [18:0] p_stat;
    always @(negedge clk) begin
        logic [8:0] e;
        stat_t s;
        if (rst_n) begin
            if (p_ostall) begin
                chk("out_hold_valid", out_valid, 1'b1);
                chk("out_hold_data", {out_last, out_data}, p_out);
            end
            if (p_sstall) begin
                chk("stat_hold_valid", stat_valid, 1'b1);
                chk("stat_hold", {stat_crc_ok, stat_runt, stat_too_long, stat_len}, p_stat);
            end
            if (out_valid && !out_ready) chk("in_ready_out_stall", in_ready, 1'b0);
            if (stat_valid) chk("in_ready_stat", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                out_hs++;
                if (exp_out.size() == 0) begin
                    chk("unexpected_out", {out_last, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_byte", {out_last, out_data}, e);
                end
            end
            if (stat_valid && stat_ready) begin
                stat_hs++;
                stat_hs_cyc = cyc;
                last_stat = '{stat_crc_ok, stat_runt, stat_too_long, stat_len};
                if (exp_stat.size() == 0) begin
                    chk("unexpected_stat", {stat_crc_ok, stat_runt, stat_too_long, stat_len}, 32'hFFFF_FFFF);
                end else begin
                    s = exp_stat.pop_front();
                    chk("stat_fields", {stat_crc_ok, stat_runt, stat_too_long, stat_len},
                        {s.ok, s.runt, s.tl, s.len});
                end
            end
        end
        p_ostall = rst_n && out_valid && !out_ready;
        p_sstall = rst_n && stat_valid && !stat_ready;
        p_out    = {out_last, out_data};
        p_stat   = {stat_crc_ok, stat_runt, stat_too_long, stat_len};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t good, bad, runt, p, f;
        int hs0, plen;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out", {out_valid, out_last, out_data}, 32'd0);
        chk("rst_stat", {stat_valid, stat_crc_ok, stat_runt, stat_too_long, stat_len}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(good);
        chk("good_status", {last_stat.ok, last_stat.runt, last_stat.tl}, 3'b100);
        chk("good_len", last_stat.len, 16'd9);

        bad = good;
        bad[4] = 8'h34;
        run_frame(bad);
        chk("bad_crc_ok", last_stat.ok, 1'b0);
        chk("bad_len", last_stat.len, 16'd9);

        runt = '{8'hAA, 8'hBB, 8'hCC};
        hs0 = out_hs;
        run_frame(runt);
        chk("runt_status", {last_stat.ok, last_stat.runt}, 2'b01);
        chk("runt_len", last_stat.len, 16'd0);
        chk("runt_no_payload", 32'(out_hs - hs0), 32'd0);

        out_mode = 1;
        stat_wait = 5;
        run_frame(good);
        chk("bp_crc_ok", last_stat.ok, 1'b1);
        chk("bp_len", last_stat.len, 16'd9);
        out_mode = 0;
        stat_wait = 0;

        hs0 = stat_hs;
        expect_frame(good);
        expect_frame(good);
        send_bytes(good, good.size(), 1'b1);
        send_bytes(good, good.size(), 1'b0);
        chk("b2b_restart_gap", 32'(start_cyc - stat_hs_cyc), 32'd1);
        drain();
        chk("b2b_stat_count", 32'(stat_hs - hs0), 32'd2);
        chk("b2b_crc_ok", last_stat.ok, 1'b1);

        hs0 = stat_hs;
        exp_out.push_back({1'b0, good[0]});
        send_bytes(good, 6, 1'b1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_out", {out_valid, out_last, out_data}, 32'd0);
        chk("mid_rst_stat", {stat_valid, stat_crc_ok, stat_runt, stat_too_long, stat_len}, 32'd0);
        chk("mid_rst_emitted", 32'(exp_out.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(good);
        chk("post_rst_stat_count", 32'(stat_hs - hs0), 32'd1);
        chk("post_rst_crc_ok", last_stat.ok, 1'b1);
        chk("post_rst_len", last_stat.len, 16'd9);

        gaps = 1'b1;
        for (int k = 0; k < 40; k++) begin
            out_mode  = $urandom_range(0, 2);
            stat_wait = $urandom_range(0, 3);
            p.delete();
            if (k >= 2 && $urandom_range(0, 7) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) p.push_back(8'($urandom));
                f = p;
            end else begin
                plen = (k == 0) ? TB_MAX : (k == 1) ? TB_MAX + 1 : int'($urandom_range(1, 24));
                for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
                f = with_fcs(p);
                if ($urandom_range(0, 2) == 0) begin
                    plen = $urandom_range(0, f.size() - 1);
                    f[plen] = f[plen] ^ (8'h01 << $urandom_range(0, 7));
                end
            end
            expect_frame(f);
            send_bytes(f, f.size(), 1'b0);
            if (k == 0) begin
                drain();
                chk("len_at_max_not_long", {last_stat.tl, last_stat.len}, {1'b0, 16'(TB_MAX)});
            end else if (k == 1) begin
                drain();
                chk("len_over_max_long", {last_stat.tl, last_stat.len}, {1'b1, 16'(TB_MAX + 1)});
            end
        end
        drain();
        chk("exp_out_empty", 32'(exp_out.size()), 32'd0);
        chk("exp_stat_empty", 32'(exp_stat.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
